wave_mixer_n: RTL



---
 rtl/wave_mixer_n.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/wave_mixer_n.sv
// wave_mixer_n: N-channel waveform mixer.
// Each channel has a phase accumulator, a saw/square/triangle/off waveform
// and amplitude scaling. The channels are summed through a registered
// pairwise adder tree, and the sum is saturated to W bits with a clip flag.
// The pipeline runs accumulator -> stage A -> L tree levels -> output.
module wave_mixer_n #(
   parameter int NCH = 4,
   parameter int W   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NCH*W-1:0]    amps,
   input  logic [NCH*W-1:0]    offsets,
   input  logic [NCH*W-1:0]    phasewords,
   input  logic [NCH*2-1:0]    modes,
   input  logic                sync,
   output logic signed [W-1:0] results,
   output logic                result_valid,
   output logic                clip
);

   localparam int L   = $clog2(NCH);
   localparam int LAT = 2 + L;
   // Tree nodes carry enough headroom for the full sum of NCH channels.
   localparam int SW  = W + L;
   // Heap-ordered tree: root at 0, children of j at 2j+1 / 2j+2,
   // leaves (stage A) at NCH-1 .. 2*NCH-2.
   localparam int NN  = 2 * NCH - 1;

   localparam logic signed [W-1:0]    MAXV  = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]    MINV  = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W-1:0]    NMAXV = {1'b1, {(W-2){1'b0}}, 1'b1};
   localparam logic signed [2*W-1:0]  PMAX  = (2*W)'(MAXV);
   localparam logic signed [2*W-1:0]  PMIN  = (2*W)'(MINV);
   localparam logic signed [SW-1:0]   SMAX  = SW'(MAXV);
   localparam logic signed [SW-1:0]   SMIN  = SW'(MINV);

   // Waveform lookup from phase p and a 2-bit mode.
   function automatic logic signed [W-1:0] wave(input logic [W-1:0] p,
                                                input logic [1:0]   mode);
      logic [W-1:0]        t;
      logic signed [W-1:0] s;
      // Triangle ramps up over the first half-period and down over the second;
      // flipping the MSB afterwards subtracts 2^(W-1) modulo 2^W.
      t = p[W-1] ? {~p[W-2:0], 1'b0} : {p[W-2:0], 1'b0};
      case (mode)
         2'b00:   s = {~p[W-1], p[W-2:0]};
         2'b01:   s = p[W-1] ? NMAXV : MAXV;
         2'b10:   s = {~t[W-1], t[W-2:0]};
         default: s = '0;
      endcase
      return s;
   endfunction

   // Floor-shift a full product back to Q1.(W-1) and saturate.
   // The result is {overflow, value}.
   function automatic logic [W:0] sat_prod(input logic signed [2*W-1:0] x);
      logic signed [2*W-1:0] q;
      logic [W:0]            r;
      q = x >>> (W-1);
      if (q > PMAX)      r = {1'b1, MAXV};
      else if (q < PMIN) r = {1'b1, MINV};
      else               r = {1'b0, q[W-1:0]};
      return r;
   endfunction

   // Saturate the tree sum to W bits. The result is {overflow, value}.
   function automatic logic [W:0] sat_sum(input logic signed [SW-1:0] x);
      logic [W:0] r;
      if (x > SMAX)      r = {1'b1, MAXV};
      else if (x < SMIN) r = {1'b1, MINV};
      else               r = {1'b0, x[W-1:0]};
      return r;
   endfunction

   // Sample times amplitude. The full product is exact in 2W bits.
   function automatic logic [W:0] scale(input logic signed [W-1:0] s,
                                        input logic signed [W-1:0] a);
      logic signed [2*W-1:0] prod;
      prod = (2*W)'(s) * (2*W)'(a);
      return sat_prod(prod);
   endfunction

   logic [W-1:0]          acc_p0  [NCH];
   logic [W:0]            scl_c   [NCH];
   logic signed [SW-1:0]  node_p  [NN];
   logic                  nclip_p [NN];
   logic [W:0]            fsum_c;
   logic [LAT-1:0]        vld_p;

   // ---- stage 0: phase accumulators (sync clears, overriding the increment)
   // Advance each channel's phase accumulator, or clear all of them on sync.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) acc_p0[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (sync) acc_p0[i] <= '0;
            else      acc_p0[i] <= acc_p0[i] + phasewords[i*W +: W];
         end
      end
   end

   // Phase, waveform and scaling per channel. Amplitudes, offsets and modes
   // are sampled with the accumulator value they pair with.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         scl_c[i] = scale(wave(acc_p0[i] + offsets[i*W +: W], modes[i*2 +: 2]),
                          amps[i*W +: W]);
      end
   end

   // ---- stage A (tree leaves) and L adder-tree levels
   // Register the scaled leaves, then pairwise-add one tree level per clock
   // while OR-reducing the clip bits alongside the data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < NN; j++) begin
            node_p[j]  <= '0;
            nclip_p[j] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            node_p[NCH-1+i]  <= SW'($signed(scl_c[i][W-1:0]));
            nclip_p[NCH-1+i] <= scl_c[i][W];
         end
         for (int j = 0; j < NCH-1; j++) begin
            node_p[j]  <= node_p[2*j+1] + node_p[2*j+2];
            nclip_p[j] <= nclip_p[2*j+1] | nclip_p[2*j+2];
         end
      end
   end

   assign fsum_c = sat_sum(node_p[0]);

   // ---- output stage: final saturation, clip and valid qualification
   // Register the saturated sum and clip, and shift in valid after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         results <= '0;
         clip    <= 1'b0;
         vld_p   <= '0;
      end else begin
         results <= fsum_c[W-1:0];
         clip    <= fsum_c[W] | nclip_p[0];
         vld_p   <= {vld_p[LAT-2:0], 1'b1};
      end
   end

   assign result_valid = vld_p[LAT-1];

endmodule
